// File: rtl/ttest_acc_pkg.sv
// Shared defaults and result types for the tTest product accumulator.
package ttest_acc_pkg;

  localparam int unsigned DEF_DIN_WIDTH = 40;
  localparam int unsigned DEF_ACC_WIDTH = 48;
  localparam int unsigned DEF_ACC_LEN   = 16;
  localparam int unsigned DEF_CNT_WIDTH = $clog2(DEF_ACC_LEN + 1);

  typedef logic [DEF_ACC_WIDTH-1:0] acc_t;

  typedef struct packed {
    acc_t                     sum;
    logic [DEF_CNT_WIDTH-1:0] count;
    logic                     ovf;
  } acc_result_t;

endpackage

// File: rtl/ttest_acc_add.sv
// Accumulator adder returning sum and carry-out.
// TTEST_ACC_SAT_EN: clamp the sum to all-ones on carry instead of wrapping.
module ttest_acc_add
  import ttest_acc_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] a_i,
  input  logic [ACC_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 carry_o
);

  logic [ACC_WIDTH:0] raw;

  always_comb begin
    raw     = {1'b0, a_i} + {1'b0, b_i};
    carry_o = raw[ACC_WIDTH];
`ifdef TTEST_ACC_SAT_EN
    // An all-ones accumulator re-saturates on any non-zero addend, so it sticks.
    sum_o   = carry_o ? '1 : raw[ACC_WIDTH-1:0];
`else
    sum_o   = raw[ACC_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/ttest_product_accumulator.sv
// Sums blocks of ACC_LEN multiplier products into a one-entry valid/ready output.
// TTEST_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module ttest_product_accumulator
  import ttest_acc_pkg::*;
#(
  parameter int unsigned ID        = 1,
  parameter int unsigned DIN_WIDTH = DEF_DIN_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned ACC_LEN   = DEF_ACC_LEN,
  parameter int unsigned CNT_WIDTH = $clog2(ACC_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [DIN_WIDTH-1:0] in_data,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(ACC_LEN - 1);

  logic [ACC_WIDTH-1:0] acc_q, acc_d, add_sum, sum_new;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_new;
  logic                 ovf_q, ovf_d, add_carry, ovf_new;
  logic                 ov_q, ov_d;
  logic [ACC_WIDTH-1:0] osum_q, osum_d;
  logic [CNT_WIDTH-1:0] ocnt_q, ocnt_d;
  logic                 oovf_q, oovf_d;
  logic                 accept, out_free, close;

  ttest_acc_add #(.ACC_WIDTH(ACC_WIDTH)) u_add (
    .a_i     (acc_q),
    .b_i     (ACC_WIDTH'(in_data)),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_comb begin
    in_ready = !((cnt_q == LAST) && ov_q && !out_ready);
    accept   = ce && in_valid && in_ready;
    out_free = !ov_q || out_ready;
    sum_new  = accept ? add_sum : acc_q;
    ovf_new  = ovf_q || (accept && add_carry);
    cnt_new  = cnt_q + CNT_WIDTH'(accept);
    // A held output blocks a flush; the beat-driven close is already gated by in_ready.
    close    = (accept && (cnt_q == LAST)) ||
               (ce && flush && out_free && ((cnt_q != '0) || accept));

    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    ov_d   = ov_q;
    osum_d = osum_q;
    ocnt_d = ocnt_q;
    oovf_d = oovf_q;

    if (close) begin
      ov_d   = 1'b1;
      osum_d = sum_new;
      ocnt_d = cnt_new;
      oovf_d = ovf_new;
      acc_d  = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      if (accept) begin
        acc_d = sum_new;
        cnt_d = cnt_new;
        ovf_d = ovf_new;
      end
      if (ce && ov_q && out_ready) ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      ov_q   <= 1'b0;
      osum_q <= '0;
      ocnt_q <= '0;
      oovf_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      ov_q   <= ov_d;
      osum_q <= osum_d;
      ocnt_q <= ocnt_d;
      oovf_q <= oovf_d;
    end
  end

  always_comb begin
    out_valid = ov_q;
    out_sum   = osum_q;
    out_count = ocnt_q;
    out_ovf   = oovf_q;
  end

endmodule
